// File: rtl/rom_reader_pkg.sv
// Shared constants for the ROM dump controller: FSM encodings, mode values and
// the socket-enable decoder.
package rom_reader_pkg;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSetup  = 3'd1;
    localparam logic [2:0] StWait   = 3'd2;
    localparam logic [2:0] StSample = 3'd3;
    localparam logic [2:0] StEmit   = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Out-of-range indices decode to all zeros so no socket is enabled.
    function automatic logic [31:0] onehot_decode(input int unsigned idx, input int unsigned n);
        logic [31:0] res;
        res = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            res[i[4:0]] = (i == idx) && (i < n);
        end
        return res;
    endfunction

endpackage

// File: rtl/rom_dump_controller_if.sv
// Output word stream: the controller drives data/address/valid, the sink answers
// with ready.
interface rom_dump_controller_if #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 9
);
    logic [DATA_WIDTH-1:0]    out_data;
    logic [ADDRESS_WIDTH-1:0] out_address;
    logic                     out_valid;
    logic                     out_ready;

    modport master (output out_data, output out_address, output out_valid, input out_ready);
    modport slave  (input out_data, input out_address, input out_valid, output out_ready);
endinterface

// File: rtl/button_debouncer.sv
// Button conditioner: 2-flop synchroniser, stability filter, and a one-cycle
// pulse on each accepted rising edge.
module button_debouncer
    import rom_reader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pulse_q, pulse_d;
    logic            accept;

    assign accept = (sync2_q != stable_q) && (cnt_q == CntW'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        pulse_d  = accept && sync2_q;
        // Any disagreement shorter than the filter window restarts the count.
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d    = '0;
            stable_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/rom_dump_controller.sv
// Multi-socket ROM reader: manual button stepping or an auto sweep of the selected
// chip, each word delivered over a valid/ready stream.
module rom_dump_controller
    import rom_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned ADDRESS_WIDTH   = 9,
    parameter int unsigned NUM_CHIPS       = 2,
    parameter int unsigned CHIP_SEL_WIDTH  = 1,
    parameter int unsigned ACCESS_CYCLES   = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHIP_SEL_WIDTH-1:0] chip_index_i,
    input  logic [ADDRESS_WIDTH-1:0]  last_address_i,
    input  logic                      auto_mode_i,
    input  logic                      start_i,
    input  logic                      increment_address_i,
    input  logic                      decrement_address_i,
    input  logic [DATA_WIDTH-1:0]     chip_data_i,
    output logic [ADDRESS_WIDTH-1:0]  chip_address_o,
    output logic [NUM_CHIPS-1:0]      chip_enable_o,
    output logic                      busy_o,
    output logic                      done_o,
    rom_dump_controller_if.master     out_if
);
    localparam int unsigned CntW = $clog2(ACCESS_CYCLES + 1);

    logic [2:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDRESS_WIDTH-1:0] last_q, last_d;
    logic                     mode_q, mode_d;
    logic [ADDRESS_WIDTH-1:0] chip_addr_q, chip_addr_d;
    logic [NUM_CHIPS-1:0]     chip_en_q, chip_en_d;
    logic [CntW-1:0]          wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic [ADDRESS_WIDTH-1:0] out_addr_q, out_addr_d;
    logic                     out_valid_q, out_valid_d;
    logic                     enter_setup;
    logic                     inc_pulse, dec_pulse;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (increment_address_i),
        .pulse_o (inc_pulse)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_db (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (decrement_address_i),
        .pulse_o (dec_pulse)
    );

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        last_d      = last_q;
        mode_d      = mode_q;
        chip_addr_d = chip_addr_q;
        chip_en_d   = chip_en_q;
        wait_cnt_d  = wait_cnt_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        enter_setup = 1'b0;

        case (state_q)
            StIdle: begin
                if (auto_mode_i && start_i) begin
                    cur_addr_d  = '0;
                    mode_d      = MODE_AUTO;
                    enter_setup = 1'b1;
                end else if (!auto_mode_i && (inc_pulse ^ dec_pulse)) begin
                    mode_d      = MODE_MANUAL;
                    enter_setup = 1'b1;
                    if (inc_pulse) begin
                        cur_addr_d = (cur_addr_q == last_address_i) ? '0
                                   : cur_addr_q + ADDRESS_WIDTH'(1);
                    end else begin
                        cur_addr_d = (cur_addr_q == '0) ? last_address_i
                                   : cur_addr_q - ADDRESS_WIDTH'(1);
                    end
                end
            end
            StSetup: begin
                state_d    = StWait;
                wait_cnt_d = CntW'(ACCESS_CYCLES);
            end
            StWait: begin
                if (wait_cnt_q <= CntW'(1)) begin
                    state_d = StSample;
                end else begin
                    wait_cnt_d = wait_cnt_q - CntW'(1);
                end
            end
            StSample: begin
                out_data_d  = chip_data_i;
                out_addr_d  = cur_addr_q;
                out_valid_d = 1'b1;
                state_d     = StEmit;
            end
            StEmit: begin
                if (out_if.out_ready) begin
                    out_valid_d = 1'b0;
                    if (mode_q == MODE_MANUAL) begin
                        state_d   = StIdle;
                        chip_en_d = '0;
                    end else if (cur_addr_q == last_q) begin
                        state_d   = StDone;
                        chip_en_d = '0;
                    end else begin
                        cur_addr_d  = cur_addr_q + ADDRESS_WIDTH'(1);
                        enter_setup = 1'b1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Bus and socket select are registered on entry so they are stable throughout SETUP.
        if (enter_setup) begin
            state_d     = StSetup;
            last_d      = last_address_i;
            chip_addr_d = cur_addr_d;
            chip_en_d   = NUM_CHIPS'(onehot_decode(32'(chip_index_i), NUM_CHIPS));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            last_q      <= '0;
            mode_q      <= MODE_MANUAL;
            chip_addr_q <= '0;
            chip_en_q   <= '0;
            wait_cnt_q  <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            last_q      <= last_d;
            mode_q      <= mode_d;
            chip_addr_q <= chip_addr_d;
            chip_en_q   <= chip_en_d;
            wait_cnt_q  <= wait_cnt_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign chip_address_o     = chip_addr_q;
    assign chip_enable_o      = chip_en_q;
    assign busy_o             = (state_q != StIdle);
    assign done_o             = (state_q == StDone);
    assign out_if.out_data    = out_data_q;
    assign out_if.out_address = out_addr_q;
    assign out_if.out_valid   = out_valid_q;

endmodule

// File: tb/tb_rom_dump_controller.sv
// Directed bench for rom_dump_controller: sweeps, backpressure, manual stepping,
// access latency and mid-sweep reset.
module tb_rom_dump_controller;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 9;
    localparam int unsigned NC = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [0:0]    chip_index = '0;
    logic [AW-1:0] last_address = '0;
    logic          auto_mode = 1'b0;
    logic          start = 1'b0;
    logic          inc_btn = 1'b0;
    logic          dec_btn = 1'b0;
    logic [DW-1:0] chip_data;
    logic [AW-1:0] chip_address;
    logic [NC-1:0] chip_enable;
    logic          busy, done;
    logic          rom_ovr_en = 1'b0;
    logic [7:0]    rom_ovr = 8'h00;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rom_dump_controller_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) out_if ();

    assign chip_data = rom_ovr_en ? rom_ovr : (chip_address[7:0] ^ 8'hA5);

    rom_dump_controller #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CHIPS(NC), .CHIP_SEL_WIDTH(1),
        .ACCESS_CYCLES(4), .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .chip_index_i        (chip_index),
        .last_address_i      (last_address),
        .auto_mode_i         (auto_mode),
        .start_i             (start),
        .increment_address_i (inc_btn),
        .decrement_address_i (dec_btn),
        .chip_data_i         (chip_data),
        .chip_address_o      (chip_address),
        .chip_enable_o       (chip_enable),
        .busy_o              (busy),
        .done_o              (done),
        .out_if              (out_if)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        start = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0; rom_ovr_en = 1'b0;
        out_if.out_ready = 1'b1;
        reset = 1'b1;
        repeat (2) tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic wait_valid(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick;
            if (out_if.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Holds the button(s) until a word appears or the budget runs out, then releases.
    task automatic press(input logic inc, input logic dec, output logic got,
                         output logic [AW-1:0] addr, output logic [DW-1:0] data);
        inc_btn = inc; dec_btn = dec;
        got = 1'b0; addr = '0; data = '0;
        for (int i = 0; i < 80; i++) begin
            tick;
            if (out_if.out_valid && !got) begin
                got = 1'b1; addr = out_if.out_address; data = out_if.out_data;
            end
        end
        inc_btn = 1'b0; dec_btn = 1'b0;
        repeat (40) tick;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_if.out_valid); end
        checks++; if (out_if.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", out_if.out_data); end
        checks++; if (out_if.out_address !== 9'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", out_if.out_address); end
        checks++; if (chip_address !== 9'd0) begin errors++; $display("FAIL reset_chip_addr got=%0d want=0", chip_address); end
        checks++; if (chip_enable !== 2'b00) begin errors++; $display("FAIL reset_enable got=%b want=00", chip_enable); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
        do_reset;
    endtask

    task automatic test_auto_sweep_chip1;
        int words = 0, dones = 0, bad_en = 0;
        logic after_done = 1'b0, fell = 1'b0;
        do_reset;
        auto_mode = 1'b1; chip_index = 1'b1; last_address = 9'd511;
        start = 1'b1; tick; start = 1'b0;
        for (int c = 0; c < 4200; c++) begin
            tick;
            if (after_done) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    errors++; $display("FAIL sweep1_busy_after_done busy=%b done=%b want=00", busy, done);
                end
                fell = 1'b1;
                break;
            end
            if (out_if.out_valid) begin
                checks++;
                if (out_if.out_address !== words[8:0] || out_if.out_data !== (words[7:0] ^ 8'hA5)) begin
                    errors++;
                    $display("FAIL sweep1_word got=%0d/%h want=%0d/%h", out_if.out_address,
                             out_if.out_data, words, words[7:0] ^ 8'hA5);
                end
                words++;
            end
            if (busy && !done && chip_enable !== 2'b10) bad_en++;
            if (done) begin dones++; after_done = 1'b1; end
        end
        checks++; if (words != 512) begin errors++; $display("FAIL sweep1_count got=%0d want=512", words); end
        checks++; if (dones != 1) begin errors++; $display("FAIL sweep1_done_pulses got=%0d want=1", dones); end
        checks++; if (bad_en != 0) begin errors++; $display("FAIL sweep1_enable bad_cycles=%0d want=0", bad_en); end
        checks++; if (!fell) begin errors++; $display("FAIL sweep1_timeout finished=0 want=1"); end
    endtask

    task automatic test_auto_sweep_backpressure;
        int words = 0, dones = 0;
        logic pend = 1'b0;
        logic [7:0] hd = '0;
        logic [AW-1:0] ha = '0;
        do_reset;
        auto_mode = 1'b1; chip_index = 1'b0; last_address = 9'd255;
        start = 1'b1; tick; start = 1'b0;
        for (int c = 0; c < 9000 && dones == 0; c++) begin
            tick;
            if (done) dones++;
            out_if.out_ready = 1'($urandom_range(0, 1));
            if (out_if.out_valid) begin
                if (pend) begin
                    checks++;
                    if (out_if.out_data !== hd || out_if.out_address !== ha) begin
                        errors++; $display("FAIL bp_stable got=%0d/%h want=%0d/%h",
                                           out_if.out_address, out_if.out_data, ha, hd);
                    end
                end
                if (out_if.out_ready) begin
                    checks++;
                    if (out_if.out_address !== words[8:0] || out_if.out_data !== (words[7:0] ^ 8'hA5)) begin
                        errors++; $display("FAIL bp_word got=%0d/%h want=%0d/%h", out_if.out_address,
                                           out_if.out_data, words, words[7:0] ^ 8'hA5);
                    end
                    words++; pend = 1'b0;
                end else begin
                    pend = 1'b1; hd = out_if.out_data; ha = out_if.out_address;
                end
            end
        end
        checks++; if (words != 256) begin errors++; $display("FAIL bp_count got=%0d want=256", words); end
        checks++; if (dones != 1) begin errors++; $display("FAIL bp_done got=%0d want=1", dones); end
        out_if.out_ready = 1'b1;
    endtask

    task automatic test_manual;
        int exp_addr [7] = '{1, 2, 3, 2, 1, 0, 255};
        logic got;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic seen = 1'b0;
        do_reset;
        auto_mode = 1'b0; chip_index = 1'b0; last_address = 9'd255;
        for (int b = 0; b < 4; b++) begin
            inc_btn = 1'b1; repeat (5) tick;
            inc_btn = 1'b0; repeat (5) tick;
        end
        for (int i = 0; i < 40; i++) begin
            tick;
            if (out_if.out_valid || busy) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL manual_bounce word_seen=1 want=0"); end
        for (int p = 0; p < 7; p++) begin
            press(p < 3, p >= 3, got, a, d);
            checks++;
            if (!got || a !== exp_addr[p][8:0] || d !== (exp_addr[p][7:0] ^ 8'hA5)) begin
                errors++; $display("FAIL manual_step%0d got=%b/%0d/%h want=1/%0d/%h", p, got, a, d,
                                   exp_addr[p], exp_addr[p][7:0] ^ 8'hA5);
            end
        end
    endtask

    task automatic test_both_buttons;
        logic got;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        do_reset;
        auto_mode = 1'b0; chip_index = 1'b0; last_address = 9'd255;
        press(1'b1, 1'b1, got, a, d);
        checks++; if (got) begin errors++; $display("FAIL both_buttons got_word=1 want=0"); end
        press(1'b1, 1'b0, got, a, d);
        checks++; if (!got || a !== 9'd1) begin errors++; $display("FAIL both_then_inc got=%b/%0d want=1/1", got, a); end
    endtask

    task automatic test_latency;
        do_reset;
        auto_mode = 1'b1; chip_index = 1'b0; last_address = 9'd3;
        out_if.out_ready = 1'b0; rom_ovr_en = 1'b1; rom_ovr = 8'h00;
        start = 1'b1; tick; start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick;
            if (k == 2) rom_ovr = 8'h11;
            if (k == 4) rom_ovr = 8'h22;
            if (k == 5) rom_ovr = 8'h33;
            if (k == 3) begin
                checks++;
                if (chip_enable !== 2'b01 || chip_address !== 9'd0) begin
                    errors++; $display("FAIL lat_bus got=%b/%0d want=01/0", chip_enable, chip_address);
                end
            end
            checks++;
            if (out_if.out_valid !== (k == 6)) begin
                errors++; $display("FAIL lat_valid_edge%0d got=%b want=%b", k, out_if.out_valid, k == 6);
            end
        end
        checks++; if (out_if.out_data !== 8'h33) begin errors++; $display("FAIL lat_sample got=%h want=33", out_if.out_data); end
        rom_ovr = 8'h44;
        tick;
        checks++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== 8'h33 || out_if.out_address !== 9'd0) begin
            errors++; $display("FAIL lat_hold got=%b/%h/%0d want=1/33/0", out_if.out_valid,
                               out_if.out_data, out_if.out_address);
        end
        do_reset;
    endtask

    task automatic test_reset_mid_sweep;
        logic ok = 1'b0;
        do_reset;
        auto_mode = 1'b1; chip_index = 1'b1; last_address = 9'd511;
        start = 1'b1; tick; start = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            tick;
            if (out_if.out_valid && out_if.out_address == 9'd100) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL midrst_reach100 got=0 want=1"); end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (out_if.out_valid !== 1'b0 || out_if.out_data !== 8'h00 || out_if.out_address !== 9'd0) begin
            errors++; $display("FAIL midrst_out got=%b/%h/%0d want=0/00/0", out_if.out_valid,
                               out_if.out_data, out_if.out_address);
        end
        checks++;
        if (chip_address !== 9'd0 || chip_enable !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midrst_bus got=%0d/%b/%b/%b want=0/00/0/0", chip_address,
                               chip_enable, busy, done);
        end
        tick;
        reset = 1'b0;
        tick;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_idle got=%b%b want=00", busy, done); end
        start = 1'b1; tick; start = 1'b0;
        wait_valid(20, ok);
        checks++;
        if (!ok || out_if.out_address !== 9'd0 || out_if.out_data !== 8'hA5) begin
            errors++; $display("FAIL midrst_restart got=%b/%0d/%h want=1/0/a5", ok,
                               out_if.out_address, out_if.out_data);
        end
        do_reset;
    endtask

    initial begin
        out_if.out_ready = 1'b1;
        test_reset;
        test_latency;
        test_auto_sweep_chip1;
        test_auto_sweep_backpressure;
        test_manual;
        test_both_buttons;
        test_reset_mid_sweep;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_dump_controller.md
Name: rom_dump_controller

Overview:
Parametrised successor to the single-chip ROM reader pair. One controller serves NUM_CHIPS sockets of differing depth, selected at run time.
- Manual mode: debounced increment/decrement buttons step the address, and each step performs one read.
- Auto mode: a start pulse sweeps 0..last_address and streams every word out over a valid/ready handshake.
- Sits between the board I/O (buttons, sockets, LEDs) and a downstream sink (UART or LED mux).

Parameters:
DATA_WIDTH, 8, width of chip data bus and output word
ADDRESS_WIDTH, 9, width of chip address bus
NUM_CHIPS, 2, number of sockets, each with one enable line
CHIP_SEL_WIDTH, 1, width of chip index (>= clog2(NUM_CHIPS))
ACCESS_CYCLES, 4, clk cycles between address/enable setup and data sampling (>=1)
DEBOUNCE_CYCLES, 16, cycles a button must be stable before it is accepted

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
chip_index  input  CHIP_SEL_WIDTH  socket to read; latched on entry to SETUP
last_address  input  ADDRESS_WIDTH  highest valid address of selected chip (e.g. 255 or 511); latched with chip_index
auto_mode  input  1  0 = manual stepping, 1 = auto sweep
start  input  1  auto sweep request; level-sampled in IDLE
increment_address  input  1  raw button, active-high
decrement_address  input  1  raw button, active-high
chip_data_in  input  DATA_WIDTH  ROM data bus
chip_address  output  ADDRESS_WIDTH  ROM address bus
chip_enable  output  NUM_CHIPS  one-hot active-high socket enable
out_data  output  DATA_WIDTH  sampled word
out_address  output  ADDRESS_WIDTH  address of out_data
out_valid  output  1  word available
out_ready  input  1  sink accepts word
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at end of auto sweep

Behaviour:
- Reset values: state IDLE; all outputs and internal registers 0.
- States: IDLE, SETUP, WAIT, SAMPLE, EMIT, DONE.
- IDLE:
  - If auto_mode and start: cur_addr <= 0, go to SETUP.
  - Else if !auto_mode and a debounced rising edge occurs on exactly one button: cur_addr <= cur_addr ±1, go to SETUP.
  - Increment wraps from last_address to 0; decrement wraps from 0 to last_address.
  - Both edges in the same cycle: ignored, no state change.
  - Button edges are ignored outside IDLE and are not queued.
- SETUP (1 cycle): latch chip_index and last_address; drive chip_address = cur_addr and chip_enable = one-hot(chip_index). chip_index >= NUM_CHIPS gives chip_enable = 0; the read still completes and returns whatever is on the bus.
- WAIT: hold address and enable for ACCESS_CYCLES cycles (down-counter), then go to SAMPLE.
- SAMPLE (1 cycle): at its end, out_data <= chip_data_in, out_address <= cur_addr, out_valid <= 1. Go to EMIT.
- EMIT: out_valid stays high, and out_data/out_address stay stable, until out_ready is high. On the accepting edge out_valid <= 0, then:
  - Manual mode: go to IDLE.
  - Auto mode with cur_addr == last_address: go to DONE.
  - Auto mode otherwise: cur_addr + 1, go to SETUP.
- DONE: done = 1 for one cycle, then IDLE.
- chip_address and chip_enable are held from SETUP through EMIT, so the bus stays driven during backpressure. chip_enable = 0 in IDLE and DONE; chip_address retains its last value.
- Start-to-valid latency: out_valid rises ACCESS_CYCLES+2 edges after the edge that samples start. Per-word period with out_ready held high: ACCESS_CYCLES+3 cycles.
- auto_mode changing mid-sweep: ignored; the mode is latched in SETUP of the first word.
- Asserting reset mid-sweep forces IDLE immediately, with no done pulse; a partial word is never emitted.
- Address arithmetic is modulo 2^ADDRESS_WIDTH; the compare against last_address uses the latched value.

Decomposition:
- Shared package/include rom_reader_pkg: state encodings, mode constants (MODE_MANUAL = 0, MODE_AUTO = 1), one-hot decode function.
- Sub-module button_debouncer (parameter DEBOUNCE_CYCLES), instantiated twice. Output: a one-cycle rising-edge pulse after the input has been stable high for DEBOUNCE_CYCLES; 2-flop input synchroniser.

Test Plan:
- Auto sweep, chip 1, last_address = 511, ROM model data = addr[7:0]^8'hA5, out_ready = 1 -> 512 words in order 0..511, correct data, chip_enable = 2'b10 throughout; done pulses exactly once; busy falls on the cycle after done.
- Auto sweep, chip 0, last_address = 255, out_ready toggled randomly -> 256 words, none lost or duplicated; out_data/out_address stable while out_valid && !out_ready.
- Manual mode from reset, 3 increment presses then 4 decrement presses -> emitted addresses 1, 2, 3, 2, 1, 0, last_address (wrap); bounces shorter than DEBOUNCE_CYCLES produce no words.
- Both buttons rising on the same cycle in IDLE -> no word emitted, cur_addr unchanged.
- ACCESS_CYCLES = 4, start at edge 0 -> out_valid high after edge 6; ROM data changed during WAIT is sampled only at the SAMPLE edge.
- Reset asserted at address 100 mid-sweep -> all outputs 0 asynchronously, no done; a new start sweeps again from address 0.
